pdl_eval_sequencer: RTL and testbench

Sequences the dual-core PDL arbiter PUF through a full 32-bit-position evaluation. It receives 256 configuration words from the host-facing FSM over a valid/ready stream and assembles them into per-bit 125-bit PDL configurations for core 0 and core 1. It then steps through bit positions 0..31: it drives each configuration pair, waits for the delay lines to settle, launches the PUF, and collects both cores' response bits into two 32-bit results. It sits between the SIRC user FSM (memory/register handshakes) and `top_PUF`, replacing the static bit-0 configuration hookup.

---
 rtl/pdl_seq_defs.sv | 20 ++
 rtl/pdl_cfg_bank.sv | 41 ++++
 rtl/pdl_eval_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_pdl_eval_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdl_seq_defs.sv
// Shared definitions for the PDL evaluation sequencer.
// PDL_MAJORITY_VOTE_EN selects three launches per bit with 2-of-3 voting.
package pdl_seq_defs;

  localparam int PDL_CFG_BITS = 125;
  localparam int PUF_NUM_BITS = 32;
  localparam int CFG_WORDS    = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SET,
    S_SETTLE,
    S_LAUNCH,
    S_WAIT_RESP,
    S_NEXT,
    S_FINISH
  } seq_state_e;

endpackage

// File: rtl/pdl_cfg_bank.sv
// 2 x 32 x 125-bit PDL configuration storage.
// Written one 32-bit slice per word index, read as a full entry per bit.
module pdl_cfg_bank
  import pdl_seq_defs::*;
(
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [7:0]              waddr_i,
  input  logic [31:0]             wdata_i,
  input  logic [4:0]              raddr_i,
  output logic [PDL_CFG_BITS-1:0] rdata0_o,
  output logic [PDL_CFG_BITS-1:0] rdata1_o
);

  logic [PDL_CFG_BITS-1:0] mem_q [2][PUF_NUM_BITS];
  logic [PDL_CFG_BITS-1:0] rd0_q;
  logic [PDL_CFG_BITS-1:0] rd1_q;
  logic                    core;
  logic [4:0]              wbit;
  logic [1:0]              slice;

  assign {core, wbit, slice} = waddr_i;

  // Slice 3 only has 29 live bits; the top three data bits are dropped.
  always_ff @(posedge clk) begin
    if (we_i) begin
      unique case (slice)
        2'd0: mem_q[core][wbit][31:0]   <= wdata_i;
        2'd1: mem_q[core][wbit][63:32]  <= wdata_i;
        2'd2: mem_q[core][wbit][95:64]  <= wdata_i;
        2'd3: mem_q[core][wbit][124:96] <= wdata_i[28:0];
      endcase
    end
    rd0_q <= mem_q[1'b0][raddr_i];
    rd1_q <= mem_q[1'b1][raddr_i];
  end

  assign rdata0_o = rd0_q;
  assign rdata1_o = rd1_q;

endmodule

// File: rtl/pdl_eval_sequencer.sv
// Loads PDL configs and steps the dual-core arbiter PUF through 32 bits.
// Define PDL_MAJORITY_VOTE_EN for three launches per bit with 2-of-3 voting.
module pdl_eval_sequencer
  import pdl_seq_defs::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [31:0]             cfg_data,
  output logic [PDL_CFG_BITS-1:0] pdl_cfg0,
  output logic [PDL_CFG_BITS-1:0] pdl_cfg1,
  output logic                    puf_launch,
  input  logic                    puf_resp_valid,
  input  logic                    puf_resp0,
  input  logic                    puf_resp1,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [PUF_NUM_BITS-1:0] result0,
  output logic [PUF_NUM_BITS-1:0] result1
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] WORD_LAST   = 8'(CFG_WORDS - 1);

  seq_state_e state_q;

  logic [7:0]              wcnt_q;
  logic [7:0]              scnt_q;
  logic [7:0]              tcnt_q;
  logic [4:0]              bit_q;
  logic [4:0]              rd_bit_d;
  logic                    cfg_ready_q;
  logic                    launch_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;
  logic [PUF_NUM_BITS-1:0] res0_q;
  logic [PUF_NUM_BITS-1:0] res1_q;
  logic [PDL_CFG_BITS-1:0] cfg0_q;
  logic [PDL_CFG_BITS-1:0] cfg1_q;
  logic [PDL_CFG_BITS-1:0] bank0;
  logic [PDL_CFG_BITS-1:0] bank1;
  logic                    accept;
  logic                    tmo_hit;
  logic                    resolve;
  logic                    r0;
  logic                    r1;

`ifdef PDL_MAJORITY_VOTE_EN
  logic [1:0] trial_q;
  logic [1:0] vote0_q;
  logic [1:0] vote1_q;
  logic [1:0] maj0;
  logic [1:0] maj1;

  assign maj0 = vote0_q + {1'b0, r0};
  assign maj1 = vote1_q + {1'b0, r1};
`endif

  assign accept  = cfg_valid && cfg_ready_q;
  assign tmo_hit = (tcnt_q == TMO_LAST);
  assign resolve = puf_resp_valid || tmo_hit;
  assign r0      = puf_resp_valid && puf_resp0;
  assign r1      = puf_resp_valid && puf_resp1;

  // The bank read is registered, so address it with the bit SET will use.
  assign rd_bit_d = (state_q == S_NEXT) ? bit_q + 5'd1 : bit_q;

  pdl_cfg_bank u_bank (
    .clk      (clk),
    .we_i     (accept),
    .waddr_i  (wcnt_q),
    .wdata_i  (cfg_data),
    .raddr_i  (rd_bit_d),
    .rdata0_o (bank0),
    .rdata1_o (bank1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      scnt_q      <= '0;
      tcnt_q      <= '0;
      bit_q       <= '0;
      cfg_ready_q <= 1'b0;
      launch_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      res0_q      <= '0;
      res1_q      <= '0;
      cfg0_q      <= '0;
      cfg1_q      <= '0;
`ifdef PDL_MAJORITY_VOTE_EN
      trial_q     <= '0;
      vote0_q     <= '0;
      vote1_q     <= '0;
`endif
    end else begin
      launch_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_LOAD;
            wcnt_q      <= '0;
            bit_q       <= '0;
            err_q       <= 1'b0;
            res0_q      <= '0;
            res1_q      <= '0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_LOAD: begin
          if (accept) begin
            wcnt_q <= wcnt_q + 8'd1;
            if (wcnt_q == WORD_LAST) begin
              cfg_ready_q <= 1'b0;
              state_q     <= S_SET;
            end
          end
        end
        S_SET: begin
          cfg0_q  <= bank0;
          cfg1_q  <= bank1;
          scnt_q  <= '0;
          state_q <= S_SETTLE;
`ifdef PDL_MAJORITY_VOTE_EN
          trial_q <= '0;
          vote0_q <= '0;
          vote1_q <= '0;
`endif
        end
        S_SETTLE: begin
          if (scnt_q == SETTLE_LAST) begin
            launch_q <= 1'b1;
            state_q  <= S_LAUNCH;
          end else begin
            scnt_q <= scnt_q + 8'd1;
          end
        end
        S_LAUNCH: begin
          tcnt_q  <= '0;
          state_q <= S_WAIT_RESP;
        end
        S_WAIT_RESP: begin
          if (resolve) begin
            if (!puf_resp_valid) err_q <= 1'b1;
`ifdef PDL_MAJORITY_VOTE_EN
            if (trial_q == 2'd2) begin
              res0_q[bit_q] <= maj0[1];
              res1_q[bit_q] <= maj1[1];
              state_q       <= S_NEXT;
            end else begin
              vote0_q <= maj0;
              vote1_q <= maj1;
              trial_q <= trial_q + 2'd1;
              scnt_q  <= '0;
              state_q <= S_SETTLE;
            end
`else
            res0_q[bit_q] <= r0;
            res1_q[bit_q] <= r1;
            state_q       <= S_NEXT;
`endif
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end
        S_NEXT: begin
          if (bit_q == 5'd31) begin
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            bit_q   <= bit_q + 5'd1;
            state_q <= S_SET;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign puf_launch = launch_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign result0    = res0_q;
  assign result1    = res1_q;
  assign pdl_cfg0   = cfg0_q;
  assign pdl_cfg1   = cfg1_q;

endmodule

// File: tb/tb_pdl_eval_sequencer.sv
// Randomized self-checking bench for pdl_eval_sequencer.
// Honours PDL_MAJORITY_VOTE_EN to expect three trials per bit.
module tb_pdl_eval_sequencer;

  localparam int SETTLE = 16;
  localparam int TMO    = 255;
`ifdef PDL_MAJORITY_VOTE_EN
  localparam int NT = 3;
`else
  localparam int NT = 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [31:0]  cfg_data;
  logic [124:0] pdl_cfg0;
  logic [124:0] pdl_cfg1;
  logic         puf_launch;
  logic         puf_resp_valid;
  logic         puf_resp0;
  logic         puf_resp1;
  logic         busy;
  logic         done;
  logic         err;
  logic [31:0]  result0;
  logic [31:0]  result1;

  pdl_eval_sequencer #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_data       (cfg_data),
    .pdl_cfg0       (pdl_cfg0),
    .pdl_cfg1       (pdl_cfg1),
    .puf_launch     (puf_launch),
    .puf_resp_valid (puf_resp_valid),
    .puf_resp0      (puf_resp0),
    .puf_resp1      (puf_resp1),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .result0        (result0),
    .result1        (result1)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0]  words [256];
  logic [31:0]  drop_mask;
  bit           fixed_mode;
  int           spur_at;
  int           last_hs_cyc;
  int           launch_cnt;
  int           res_cnt;
  int           last_res_cyc;
  int           sum0 [32];
  int           sum1 [32];
  bit           exp_err;
  int           hs_mon   = 0;
  int           done_cnt = 0;
  logic [124:0] cap_cfg5;
  logic [31:0]  e0;
  logic [31:0]  e1;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [124:0] exp_cfg(input int c, input int b);
    int base;
    base = c * 128 + b * 4;
    return {words[base+3][28:0], words[base+2], words[base+1], words[base]};
  endfunction

  // PUF responder plus the model's per-trial bookkeeping.
  initial begin
    bit   pend, drop, prev_busy, v0, v1;
    int   wc, delay, cur_bit, trial;
    pend = 0; prev_busy = 0; drop = 0; wc = 0; delay = 0;
    cur_bit = 0; trial = 0; v0 = 0; v1 = 0;
    launch_cnt = 0; res_cnt = 0; last_res_cyc = 0; exp_err = 0;
    for (int b = 0; b < 32; b++) begin
      sum0[b] = 0;
      sum1[b] = 0;
    end
    puf_resp_valid = 0; puf_resp0 = 0; puf_resp1 = 0;
    forever begin
      @(posedge clk);
      #1;
      puf_resp_valid = 0;
      puf_resp0 = 1'($urandom);
      puf_resp1 = 1'($urandom);
      if (reset || (start && !prev_busy)) begin
        pend = 0; launch_cnt = 0; res_cnt = 0; exp_err = 0;
        for (int b = 0; b < 32; b++) begin
          sum0[b] = 0;
          sum1[b] = 0;
        end
      end else if (puf_launch) begin
        launch_cnt++;
        pend    = 1;
        wc      = 0;
        cur_bit = (launch_cnt - 1) / NT;
        trial   = (launch_cnt - 1) % NT;
        drop    = drop_mask[cur_bit];
        if (fixed_mode) begin
          delay = 3;
          v0    = !(NT == 3 && trial == 1);
          v1    = 0;
        end else begin
          delay = $urandom_range(1, 6);
          v0    = 1'($urandom);
          v1    = 1'($urandom);
        end
      end else if (pend) begin
        wc++;
        if (!drop && wc == delay) begin
          puf_resp_valid = 1; puf_resp0 = v0; puf_resp1 = v1;
          sum0[cur_bit] += int'(v0);
          sum1[cur_bit] += int'(v1);
          pend = 0; res_cnt++; last_res_cyc = cyc;
        end else if (drop && wc == TMO) begin
          exp_err = 1;
          pend = 0; res_cnt++; last_res_cyc = cyc;
        end
      end else if (cyc == spur_at) begin
        puf_resp_valid = 1; puf_resp0 = 1; puf_resp1 = 1;
      end
      prev_busy = busy;
    end
  end

  // Compare process.
  initial forever begin
    int lc, b;
    @(negedge clk);
    #1;
    if (!reset) begin
      if (cfg_valid && cfg_ready) hs_mon++;
      if (puf_launch) begin
        lc = launch_cnt - 1;
        b  = lc / NT;
        chk("cfg0_at_launch", 128'(pdl_cfg0), 128'(exp_cfg(0, b)));
        chk("cfg1_at_launch", 128'(pdl_cfg1), 128'(exp_cfg(1, b)));
        if (lc == 0)
          chk("first_launch_gap", 128'(cyc - last_hs_cyc), 128'(SETTLE + 2));
        else
          chk("launch_gap", 128'(cyc - last_res_cyc),
              128'(SETTLE + ((lc % NT == 0) ? 3 : 1)));
        if (b == 5 && lc % NT == 0) cap_cfg5 = pdl_cfg0;
      end
      if (done) begin
        for (int i = 0; i < 32; i++) begin
          e0[i] = (sum0[i] * 2 > NT);
          e1[i] = (sum1[i] * 2 > NT);
        end
        chk("result0", 128'(result0), 128'(e0));
        chk("result1", 128'(result1), 128'(e1));
        chk("err", 128'(err), 128'(exp_err));
        chk("launch_count", 128'(launch_cnt), 128'(32 * NT));
        chk("busy_at_done", 128'(busy), 128'(1));
        done_cnt++;
      end
    end
  end

  task automatic load_words(input bit toggle, input int pulse_at);
    int hs = 0;
    int g  = 0;
    bit ph = 1;
    while (hs < 256 && g < 2000) begin
      @(negedge clk);
      g++;
      start     = (g == pulse_at);
      cfg_data  = words[hs];
      cfg_valid = toggle ? ph : 1'b1;
      ph        = ~ph;
      if (cfg_valid && cfg_ready) begin
        hs++;
        if (hs == 256) last_hs_cyc = cyc;
      end
    end
    @(negedge clk);
    start     = 0;
    cfg_valid = 1;
    chk("load_handshakes", 128'(hs), 128'(256));
    repeat (3) @(negedge clk);
    cfg_valid = 0;
  endtask

  task automatic begin_run();
    @(negedge clk);
    start = 1;
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    int g  = 0;
    while (done_cnt == d0 && g < 20000) begin
      @(negedge clk);
      g++;
    end
    chk("done_seen", 128'(done_cnt - d0), 128'(1));
    @(negedge clk);
    chk("done_one_cycle", 128'(done), 128'(0));
    chk("idle_after_done", 128'(busy), 128'(0));
  endtask

  task automatic wait_res(input int n);
    int g = 0;
    while (res_cnt < n && g < 20000) begin
      @(negedge clk);
      g++;
    end
    chk("res_progress", 128'(res_cnt >= n), 128'(1));
  endtask

  initial begin
    int          hs0;
    logic [31:0] r;
    reset = 1; start = 0; cfg_valid = 0; cfg_data = 0;
    drop_mask = 0; fixed_mode = 1; spur_at = -1;
    last_hs_cyc = 0; cap_cfg5 = '0;
    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", 128'(cfg_ready), 128'(0));
    chk("rst_launch", 128'(puf_launch), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_result0", 128'(result0), 128'(0));
    chk("rst_result1", 128'(result1), 128'(0));
    chk("rst_cfg0", 128'(pdl_cfg0), 128'(0));
    chk("rst_cfg1", 128'(pdl_cfg1), 128'(0));
    reset = 0;

    // Run A: word k = k, core 0 always wins the vote, core 1 always 0.
    for (int k = 0; k < 256; k++) words[k] = k;
    fixed_mode = 1; drop_mask = 0;
    hs0 = hs_mon;
    begin_run();
    chk("ready_after_start", 128'(cfg_ready), 128'(0));
    load_words(1'b0, 0);
    wait_done();
    chk("A_result0", 128'(result0), 128'(32'hFFFF_FFFF));
    chk("A_result1", 128'(result1), 128'(0));
    chk("A_err", 128'(err), 128'(0));
    chk("A_cfg0_bit5", 128'(cap_cfg5),
        128'({29'd23, 32'd22, 32'd21, 32'd20}));
    chk("A_launches", 128'(launch_cnt), 128'(32 * NT));
    chk("A_handshakes", 128'(hs_mon - hs0), 128'(256));

    // Run B: sparse valid, bit 7 never answers, stray start and response.
    for (int k = 0; k < 256; k++) words[k] = $urandom;
    fixed_mode = 0; drop_mask = 32'h0000_0080;
    hs0 = hs_mon;
    begin_run();
    load_words(1'b1, 60);
    wait_res(4 * NT);
    spur_at = cyc + 7;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done();
    r = result0;
    chk("B_result0_bit7", 128'(r[7]), 128'(0));
    r = result1;
    chk("B_result1_bit7", 128'(r[7]), 128'(0));
    chk("B_err", 128'(err), 128'(1));
    chk("B_handshakes", 128'(hs_mon - hs0), 128'(256));
    spur_at = -1;

    // Run C: reset lands in SETTLE of bit 12.
    for (int k = 0; k < 256; k++) words[k] = $urandom;
    drop_mask = 0;
    begin_run();
    load_words(1'b0, 0);
    wait_res(12 * NT);
    repeat (8) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("C_busy", 128'(busy), 128'(0));
    chk("C_launch", 128'(puf_launch), 128'(0));
    chk("C_result0", 128'(result0), 128'(0));
    chk("C_result1", 128'(result1), 128'(0));
    chk("C_cfg_ready", 128'(cfg_ready), 128'(0));
    chk("C_err", 128'(err), 128'(0));
    reset = 0;

    // Run D: full random run after the mid-run reset.
    for (int k = 0; k < 256; k++) words[k] = $urandom;
    drop_mask = 32'(1) << $urandom_range(0, 31);
    begin_run();
    load_words(1'b0, 0);
    wait_done();
    chk("D_err", 128'(err), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
